// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encoding and bus constants for the memory port arbiter
package arb_pkg;

    // Data/address bus width shared with the computer top level
    localparam int BUS_WIDTH = 8;

    // Arbiter FSM states, 3-bit binary
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_BND = 3'd1,
        ST_ADDR     = 3'd2,
        ST_XFER     = 3'd3,
        ST_ACK      = 3'd4,
        ST_YIELD    = 3'd5
    } arb_state_t;

    // Bits needed to count from 0 up to and including max_hold
    function automatic int hold_cnt_width(input int max_hold);
        return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - loader/debug port request/acknowledge bundle
import arb_pkg::*;

interface mem_port_arbiter_if #(
    parameter int WIDTH = BUS_WIDTH
);
    logic             ld_req;
    logic             ld_we;
    logic [WIDTH-1:0] ld_addr;
    logic [WIDTH-1:0] ld_wdata;
    logic [WIDTH-1:0] ld_rdata;
    logic             ld_ack;

    // Loader side: issues requests and holds them until ld_ack
    modport master (
        output ld_req,
        output ld_we,
        output ld_addr,
        output ld_wdata,
        input  ld_rdata,
        input  ld_ack
    );

    // Arbiter side: services requests and returns read data
    modport slave (
        input  ld_req,
        input  ld_we,
        input  ld_addr,
        input  ld_wdata,
        output ld_rdata,
        output ld_ack
    );
endinterface

// File: rtl/mem_port_arbiter_hold_counter.sv
// rtl/mem_port_arbiter_hold_counter.sv - saturating transfer counter bounding loader bus ownership
import arb_pkg::*;

module hold_counter #(
    parameter int MAX_HOLD = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic terminal
);
    localparam int CW = hold_cnt_width(MAX_HOLD);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_HOLD);

    logic [CW-1:0] count;

    assign terminal = (count == LIMIT);

    // Count transfers in the current grant; stop at the limit, clear wins over increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !terminal) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares RAM/MAR between the control unit and the loader port
import arb_pkg::*;

module mem_port_arbiter #(
    parameter int WIDTH    = BUS_WIDTH,
    parameter int MAX_HOLD = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                c_mi,
    input  logic                c_ri,
    input  logic                c_ro,
    input  logic                cpu_boundary,
    mem_port_arbiter_if.slave   ld,
    input  logic [WIDTH-1:0]    bus_in,
    output logic [WIDTH-1:0]    bus_out,
    output logic                bus_oe,
    output logic                mar_en,
    output logic                ram_we,
    output logic                ram_oe,
    output logic                cpu_hold
);
    arb_state_t       state;
    arb_state_t       state_nxt;
    logic             lat_we;
    logic [WIDTH-1:0] lat_addr;
    logic [WIDTH-1:0] lat_wdata;
    logic             latch_req;
    logic             cnt_inc;
    logic             cnt_clr;
    logic             hold_term;
    logic             pass;

    hold_counter #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_counter (
        .clk      (clk),
        .reset    (reset),
        .clr      (cnt_clr),
        .inc      (cnt_inc),
        .terminal (hold_term)
    );

    // Next-state decision; once ADDR is entered the access always runs to ACK
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (ld.ld_req) state_nxt = ST_WAIT_BND;
            ST_WAIT_BND: begin
                if (!ld.ld_req)        state_nxt = ST_IDLE;
                else if (cpu_boundary) state_nxt = ST_ADDR;
            end
            ST_ADDR:     state_nxt = ST_XFER;
            ST_XFER:     state_nxt = ST_ACK;
            ST_ACK: begin
                if (ld.ld_req && !hold_term) state_nxt = ST_ADDR;
                else if (ld.ld_req)          state_nxt = ST_YIELD;
                else                         state_nxt = ST_IDLE;
            end
            ST_YIELD:    state_nxt = ST_WAIT_BND;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Request fields are captured whenever a new request is accepted (from IDLE or at ACK)
    assign latch_req = ld.ld_req && ((state == ST_IDLE) || (state == ST_ACK));
    assign cnt_inc   = (state == ST_XFER);
    assign cnt_clr   = (state == ST_YIELD) || ((state == ST_ACK) && (state_nxt == ST_IDLE));

    // FSM state plus registered hold/bus-enable/ack outputs derived from the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            cpu_hold  <= 1'b0;
            bus_oe    <= 1'b0;
            ld.ld_ack <= 1'b0;
            ld.ld_rdata <= '0;
        end else begin
            state     <= state_nxt;
            if (latch_req) begin
                lat_we    <= ld.ld_we;
                lat_addr  <= ld.ld_addr;
                lat_wdata <= ld.ld_wdata;
            end
            cpu_hold  <= (state_nxt == ST_ADDR) || (state_nxt == ST_XFER) || (state_nxt == ST_ACK);
            bus_oe    <= (state_nxt == ST_ADDR) || ((state_nxt == ST_XFER) && lat_we);
            ld.ld_ack <= (state_nxt == ST_ACK);
            if ((state == ST_XFER) && !lat_we) begin
                ld.ld_rdata <= bus_in;
            end
        end
    end

    // CPU strobes reach MAR/RAM only in states where the loader does not own the bus
    assign pass    = (state == ST_IDLE) || (state == ST_WAIT_BND) || (state == ST_YIELD);
    assign mar_en  = pass ? c_mi : (state == ST_ADDR);
    assign ram_we  = pass ? c_ri : ((state == ST_XFER) && lat_we);
    assign ram_oe  = pass ? c_ro : ((state == ST_XFER) && !lat_we);
    assign bus_out = !bus_oe ? '0 : ((state == ST_ADDR) ? lat_addr : lat_wdata);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomised checks of mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         c_mi, c_ri, c_ro, cpu_boundary;
    logic [W-1:0] bus_in, bus_out;
    logic         bus_oe, mar_en, ram_we, ram_oe, cpu_hold;

    mem_port_arbiter_if #(.WIDTH(W)) ld_if ();

    mem_port_arbiter #(
        .WIDTH    (W),
        .MAX_HOLD (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .c_mi         (c_mi),
        .c_ri         (c_ri),
        .c_ro         (c_ro),
        .cpu_boundary (cpu_boundary),
        .ld           (ld_if.slave),
        .bus_in       (bus_in),
        .bus_out      (bus_out),
        .bus_oe       (bus_oe),
        .mar_en       (mar_en),
        .ram_we       (ram_we),
        .ram_oe       (ram_oe),
        .cpu_hold     (cpu_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tiny MAR + RAM environment on a resolved data bus
    logic [W-1:0] mem [256];
    logic [W-1:0] mar;
    assign bus_in = bus_oe ? bus_out : (ram_oe ? mem[mar] : '0);
    always @(posedge clk) begin
        if (mar_en) mar <= bus_in;
        if (ram_we) mem[mar] <= bus_in;
    end

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic         mi, ri, ro, bnd, req, we;
        logic [W-1:0] addr, wdata;
        logic         e_mar, e_we, e_oe, e_boe;
        logic [W-1:0] e_bout;
        logic         e_hold, e_ack, chk_rd;
        logic [W-1:0] e_rd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic mi, ri, ro, bnd, req, we, input logic [W-1:0] addr, wdata,
                       input logic e_mar, e_we, e_oe, e_boe, input logic [W-1:0] e_bout,
                       input logic e_hold, e_ack, chk_rd, input logic [W-1:0] e_rd);
        vec_t v;
        v.mi = mi; v.ri = ri; v.ro = ro; v.bnd = bnd; v.req = req; v.we = we;
        v.addr = addr; v.wdata = wdata;
        v.e_mar = e_mar; v.e_we = e_we; v.e_oe = e_oe; v.e_boe = e_boe; v.e_bout = e_bout;
        v.e_hold = e_hold; v.e_ack = e_ack; v.chk_rd = chk_rd; v.e_rd = e_rd;
        vecs.push_back(v);
    endtask

    logic fh [16];
    logic fa [16];
    logic fm [16];
    int   viol_excl, viol_oe, acks;

    initial begin
        reset = 1'b0;
        c_mi = 1'b1; c_ri = 1'b0; c_ro = 1'b0; cpu_boundary = 1'b0;
        ld_if.ld_req = 1'b0; ld_if.ld_we = 1'b0; ld_if.ld_addr = '0; ld_if.ld_wdata = '0;
        mar = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h20] = 8'h3C;

        // Reset state
        @(negedge clk); #1;
        chk("rst.bus_oe", bus_oe, 0);
        chk("rst.cpu_hold", cpu_hold, 0);
        chk("rst.ld_ack", ld_if.ld_ack, 0);
        chk("rst.ld_rdata", ld_if.ld_rdata, 0);
        chk("rst.mar_pass", mar_en, 1);
        @(negedge clk);
        reset = 1'b1;

        //   mi ri ro bnd req we addr   wdata   | mar we oe boe bout  hold ack rd rdval
        add(1,0,1,0, 0,0, 8'h00,8'h00,  1,0,1,0, 8'h00, 0,0, 0,8'h00);
        add(1,0,1,1, 1,1, 8'h10,8'hA5,  1,0,1,0, 8'h00, 0,0, 0,8'h00);
        add(1,0,1,1, 1,1, 8'h10,8'hA5,  1,0,1,0, 8'h00, 0,0, 0,8'h00);
        add(1,0,1,1, 1,1, 8'h10,8'hA5,  1,0,0,1, 8'h10, 1,0, 0,8'h00);
        add(1,0,1,1, 1,1, 8'h10,8'hA5,  0,1,0,1, 8'hA5, 1,0, 0,8'h00);
        add(1,0,1,1, 0,1, 8'h10,8'hA5,  0,0,0,0, 8'h00, 1,1, 0,8'h00);
        add(1,0,1,1, 0,0, 8'h00,8'h00,  1,0,1,0, 8'h00, 0,0, 0,8'h00);
        add(0,1,0,1, 1,0, 8'h20,8'h00,  0,1,0,0, 8'h00, 0,0, 0,8'h00);
        add(0,1,0,1, 1,0, 8'h20,8'h00,  0,1,0,0, 8'h00, 0,0, 0,8'h00);
        add(0,1,0,1, 1,0, 8'h20,8'h00,  1,0,0,1, 8'h20, 1,0, 0,8'h00);
        add(0,1,0,1, 1,0, 8'h20,8'h00,  0,0,1,0, 8'h00, 1,0, 0,8'h00);
        add(0,1,0,1, 0,0, 8'h20,8'h00,  0,0,0,0, 8'h00, 1,1, 1,8'h3C);
        add(0,0,1,1, 0,0, 8'h00,8'h00,  0,0,1,0, 8'h00, 0,0, 1,8'h3C);
        add(1,1,0,0, 1,1, 8'h30,8'h5A,  1,1,0,0, 8'h00, 0,0, 0,8'h00);
        add(0,0,1,0, 1,1, 8'h30,8'h5A,  0,0,1,0, 8'h00, 0,0, 0,8'h00);
        add(1,0,0,0, 1,1, 8'h30,8'h5A,  1,0,0,0, 8'h00, 0,0, 0,8'h00);
        add(0,1,0,0, 1,1, 8'h30,8'h5A,  0,1,0,0, 8'h00, 0,0, 0,8'h00);
        add(1,0,1,0, 1,1, 8'h30,8'h5A,  1,0,1,0, 8'h00, 0,0, 0,8'h00);
        add(0,0,0,0, 1,1, 8'h30,8'h5A,  0,0,0,0, 8'h00, 0,0, 0,8'h00);
        add(1,0,0,1, 1,1, 8'h30,8'h5A,  1,0,0,0, 8'h00, 0,0, 0,8'h00);
        add(1,1,0,0, 1,1, 8'h30,8'h5A,  1,0,0,1, 8'h30, 1,0, 0,8'h00);
        add(1,1,0,0, 1,1, 8'h30,8'h5A,  0,1,0,1, 8'h5A, 1,0, 0,8'h00);
        add(0,0,0,0, 0,0, 8'h00,8'h00,  0,0,0,0, 8'h00, 1,1, 0,8'h00);
        add(0,0,1,0, 0,0, 8'h00,8'h00,  0,0,1,0, 8'h00, 0,0, 0,8'h00);

        foreach (vecs[i]) begin
            @(negedge clk);
            c_mi = vecs[i].mi; c_ri = vecs[i].ri; c_ro = vecs[i].ro;
            cpu_boundary = vecs[i].bnd;
            ld_if.ld_req = vecs[i].req; ld_if.ld_we = vecs[i].we;
            ld_if.ld_addr = vecs[i].addr; ld_if.ld_wdata = vecs[i].wdata;
            #1;
            chk($sformatf("v%0d.mar_en", i), mar_en, vecs[i].e_mar);
            chk($sformatf("v%0d.ram_we", i), ram_we, vecs[i].e_we);
            chk($sformatf("v%0d.ram_oe", i), ram_oe, vecs[i].e_oe);
            chk($sformatf("v%0d.bus_oe", i), bus_oe, vecs[i].e_boe);
            chk($sformatf("v%0d.cpu_hold", i), cpu_hold, vecs[i].e_hold);
            chk($sformatf("v%0d.ld_ack", i), ld_if.ld_ack, vecs[i].e_ack);
            if (vecs[i].e_boe) chk($sformatf("v%0d.bus_out", i), bus_out, vecs[i].e_bout);
            if (vecs[i].chk_rd) chk($sformatf("v%0d.ld_rdata", i), ld_if.ld_rdata, vecs[i].e_rd);
        end
        chk("ram[10]", mem[8'h10], 8'hA5);
        chk("ram[30]", mem[8'h30], 8'h5A);

        // Fairness with MAX_HOLD=2: two grants, a YIELD, then a third after a new boundary
        fh = '{0,0,1,1,1,1,1,1,0,0,0,0,1,1,1,0};
        fa = '{0,0,0,0,1,0,0,1,0,0,0,0,0,0,1,0};
        fm = '{1,1,1,0,0,1,0,0,1,1,1,1,1,0,0,1};
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            c_mi = 1'b1; c_ri = 1'b0; c_ro = 1'b0;
            cpu_boundary = !(c == 9 || c == 10);
            ld_if.ld_req = (c < 14); ld_if.ld_we = 1'b1;
            ld_if.ld_addr = 8'h40 + W'(c); ld_if.ld_wdata = 8'h60;
            #1;
            chk($sformatf("fair%0d.cpu_hold", c), cpu_hold, fh[c]);
            chk($sformatf("fair%0d.ld_ack", c), ld_if.ld_ack, fa[c]);
            chk($sformatf("fair%0d.mar_en", c), mar_en, fm[c]);
        end

        // Reset asserted during an XFER write releases everything before the next edge
        @(negedge clk);
        c_mi = 1'b0; c_ri = 1'b0; c_ro = 1'b0; cpu_boundary = 1'b1;
        ld_if.ld_req = 1'b1; ld_if.ld_we = 1'b1; ld_if.ld_addr = 8'h44; ld_if.ld_wdata = 8'h77;
        repeat (3) @(negedge clk);
        #1;
        chk("rmid.xfer_bus_oe", bus_oe, 1);
        chk("rmid.xfer_ram_we", ram_we, 1);
        reset = 1'b0;
        #1;
        chk("rmid.bus_oe", bus_oe, 0);
        chk("rmid.cpu_hold", cpu_hold, 0);
        chk("rmid.ram_we", ram_we, 0);
        chk("rmid.bus_out", bus_out, 0);
        @(negedge clk);
        reset = 1'b1; ld_if.ld_req = 1'b0; c_mi = 1'b1;
        #1;
        chk("rpost.mar_pass", mar_en, 1);
        @(negedge clk); #1;
        chk("rpost.ld_ack", ld_if.ld_ack, 0);
        chk("rpost.cpu_hold", cpu_hold, 0);
        chk("rpost.mar_pass2", mar_en, 1);

        // Random loader/CPU traffic, checking exclusivity invariants every cycle
        viol_excl = 0; viol_oe = 0; acks = 0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            c_mi = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0: begin c_ri = 1'b1; c_ro = 1'b0; end
                1: begin c_ri = 1'b0; c_ro = 1'b1; end
                default: begin c_ri = 1'b0; c_ro = 1'b0; end
            endcase
            cpu_boundary = 1'($urandom_range(0, 1));
            if (ld_if.ld_ack) acks++;
            if (!ld_if.ld_req || ld_if.ld_ack) begin
                ld_if.ld_req = ($urandom_range(0, 3) != 0);
                ld_if.ld_we = 1'($urandom_range(0, 1));
                ld_if.ld_addr = 8'($urandom);
                ld_if.ld_wdata = 8'($urandom);
            end
            #1;
            if (ram_we && ram_oe) viol_excl++;
            if (bus_oe && !(cpu_hold && (mar_en ^ ram_we) && !ram_oe)) viol_oe++;
        end
        chk("rand.we_oe_exclusive", viol_excl, 0);
        chk("rand.bus_oe_held_masked", viol_oe, 0);
        chk("rand.acks_seen", (acks > 100), 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
